// File: rtl/nor_chk_pkg.sv
// Shared definitions for the 4-input NOR response checker: FSM states,
// coverage constants and the golden NOR reference function.
package nor_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } chk_state_t;

    localparam int          NUM_VECS = 16;
    localparam logic [15:0] COV_FULL = 16'hFFFF;

    // Returns {e, f, g}: e = ~(a|b), f = ~(c|d), g = NOR(a,b,c,d) = e & f.
    function automatic logic [2:0] nor4_expected(input logic [3:0] vec);
        logic e;
        logic f;
        e = ~(vec[3] | vec[2]);
        f = ~(vec[1] | vec[0]);
        return {e, f, e & f};
    endfunction

endpackage

// File: rtl/nor_response_checker_golden.sv
// Combinational golden model of the NOR datapath: expected e/f/g for a
// 4-bit input vector {a,b,c,d}. Usable by both the checker and stimulus side.
module nor_golden_model
    import nor_chk_pkg::*;
(
    input  logic [3:0] vec,
    output logic       exp_e,
    output logic       exp_f,
    output logic       exp_g
);

    logic [2:0] golden;

    always_comb begin
        golden = nor4_expected(vec);
        exp_e  = golden[2];
        exp_f  = golden[1];
        exp_g  = golden[0];
    end

endmodule

// File: rtl/nor_response_checker.sv
// Self-checking receiver for the 4-input NOR datapath: checks g (and, with
// NOR_STAGE_CHECK_EN defined, also e and f), tracks coverage of all 16
// vectors, counts mismatches, captures the first failure, reports
// pass/fail/timeout.
module nor_response_checker
    import nor_chk_pkg::*;
#(
    parameter int ERR_CNT_W      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 sample_valid,
    input  logic [3:0]           sample_abcd,
    input  logic                 sample_e,
    input  logic                 sample_f,
    input  logic                 sample_g,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 first_err_valid,
    output logic [3:0]           first_err_vec,
    output logic [15:0]          coverage
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;

    chk_state_t         state;
    chk_state_t         state_next;
    logic [TIMER_W-1:0] timer;

    logic        exp_e;
    logic        exp_f;
    logic        exp_g;
    logic        mismatch;
    logic        take;
    logic [15:0] cov_upd;
    logic [15:0] cov_eff;
    logic        complete;
    logic        tmo_hit;
    logic        pass_now;

    nor_golden_model u_golden (
        .vec   (sample_abcd),
        .exp_e (exp_e),
        .exp_f (exp_f),
        .exp_g (exp_g)
    );

`ifdef NOR_STAGE_CHECK_EN
    assign mismatch = (sample_g != exp_g) || (sample_e != exp_e) || (sample_f != exp_f);
`else
    logic unused_stage;
    assign unused_stage = sample_e ^ sample_f ^ exp_e ^ exp_f;
    assign mismatch     = (sample_g != exp_g);
`endif

    // A sample arriving together with start belongs to no run and is dropped.
    always_comb begin
        take     = (state == CHECK) && sample_valid && !start;
        cov_upd  = coverage | (16'd1 << sample_abcd);
        cov_eff  = take ? cov_upd : coverage;
        complete = (state == CHECK) && !start && (cov_eff == COV_FULL);
        tmo_hit  = (state == CHECK) && !start && !complete && (timer == TIMER_LAST);
        pass_now = (err_count == '0) && !(take && mismatch);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = CHECK;
            end
            CHECK: begin
                if (start)
                    state_next = CHECK;
                else if (complete || tmo_hit)
                    state_next = DONE;
            end
            DONE: begin
                if (start) state_next = CHECK;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            timer           <= '0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 4'd0;
            coverage        <= 16'd0;
        end else begin
            state <= state_next;
            busy  <= (state_next == CHECK);
            done  <= (state_next == DONE);
            if (start) begin
                timer           <= '0;
                pass            <= 1'b0;
                timeout         <= 1'b0;
                err_count       <= '0;
                first_err_valid <= 1'b0;
                first_err_vec   <= 4'd0;
                coverage        <= 16'd0;
            end else if (state == CHECK) begin
                timer <= timer + 1'b1;
                if (take) begin
                    coverage <= cov_upd;
                    if (mismatch) begin
                        if (err_count != ERR_MAX)
                            err_count <= err_count + 1'b1;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= sample_abcd;
                        end
                    end
                end
                // Completion takes priority over a simultaneous timeout.
                if (complete) begin
                    pass    <= pass_now;
                    timeout <= 1'b0;
                end else if (tmo_hit) begin
                    pass    <= 1'b0;
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nor_response_checker.sv
// Scoreboard bench for nor_response_checker: stimulus pushes expected run
// results, per-instance monitors pop and compare when done rises.
module tb_nor_response_checker;

    typedef struct {
        logic        pass;
        logic        timeout;
        logic [7:0]  err;
        logic        fv;
        logic [3:0]  fev;
        logic [15:0] cov;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        sample_valid = 1'b0;
    logic [3:0]  sample_abcd = 4'd0;
    logic        sample_e = 1'b0;
    logic        sample_f = 1'b0;
    logic        sample_g = 1'b0;

    logic        busy0, done0, pass0, timeout0, fv0;
    logic [7:0]  err0;
    logic [3:0]  fev0;
    logic [15:0] cov0;
    logic        busy1, done1, pass1, timeout1, fv1;
    logic [7:0]  err1;
    logic [3:0]  fev1;
    logic [15:0] cov1;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic done0_d = 1'b0;
    logic done1_d = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t ex0, ex1, e;
    int   s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nor_response_checker #(.ERR_CNT_W(8), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .resetn(resetn), .start(start), .sample_valid(sample_valid),
        .sample_abcd(sample_abcd), .sample_e(sample_e), .sample_f(sample_f),
        .sample_g(sample_g), .busy(busy0), .done(done0), .pass(pass0),
        .timeout(timeout0), .err_count(err0), .first_err_valid(fv0),
        .first_err_vec(fev0), .coverage(cov0)
    );

    nor_response_checker #(.ERR_CNT_W(8), .TIMEOUT_CYCLES(64)) dut64 (
        .clk(clk), .resetn(resetn), .start(start), .sample_valid(sample_valid),
        .sample_abcd(sample_abcd), .sample_e(sample_e), .sample_f(sample_f),
        .sample_g(sample_g), .busy(busy1), .done(done1), .pass(pass1),
        .timeout(timeout1), .err_count(err1), .first_err_valid(fv1),
        .first_err_vec(fev1), .coverage(cov1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic chk_res(input string tag, input exp_t x, input logic p, input logic t,
                           input logic [7:0] er, input logic f, input logic [3:0] fe,
                           input logic [15:0] cv);
        chk({tag, "_done_cycle"}, cyc, x.cyc);
        chk({tag, "_pass"}, p, x.pass);
        chk({tag, "_timeout"}, t, x.timeout);
        chk({tag, "_err_count"}, er, x.err);
        chk({tag, "_first_err_valid"}, f, x.fv);
        chk({tag, "_first_err_vec"}, fe, x.fev);
        chk({tag, "_coverage"}, cv, x.cov);
    endtask

    // Main instance: every done is expected to have a queued result.
    always @(negedge clk) begin
        if (done0 && !done0_d) begin
            if (q0.size() == 0) begin
                chk("dut_unexpected_done", 1, 0);
            end else begin
                ex0 = q0.pop_front();
                chk_res("dut", ex0, pass0, timeout0, err0, fv0, fev0, cov0);
            end
        end
        done0_d <= done0;
    end

    // Short-timeout instance: only runs with a queued result are scored.
    always @(negedge clk) begin
        if (done1 && !done1_d && q1.size() > 0) begin
            ex1 = q1.pop_front();
            chk_res("dut64", ex1, pass1, timeout1, err1, fv1, fev1, cov1);
        end
        done1_d <= done1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [3:0] v, input logic g);
        sample_valid = 1'b1;
        sample_abcd  = v;
        sample_e     = ~(v[3] | v[2]);
        sample_f     = ~(v[1] | v[0]);
        sample_g     = g;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Vectors 0..15 (skipping 'skip'), one every 2 cycles, no idle after the last.
    task automatic sweep(input int skip, input int bad, input logic bad_g);
        logic g;
        for (int v = 0; v < 16; v++) begin
            if (v == skip) continue;
            g = (v == 0);
            if (v == bad) g = bad_g;
            put(4'(v), g);
            if (v != 15) tick();
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_drain_timeout"}, q0.size() + q1.size(), 0);
    endtask

    function automatic exp_t mk(input logic p, input logic t, input logic [7:0] er,
                                input logic f, input logic [3:0] fe,
                                input logic [15:0] cv, input int c);
        exp_t r;
        r.pass = p; r.timeout = t; r.err = er; r.fv = f; r.fev = fe; r.cov = cv; r.cyc = c;
        return r;
    endfunction

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_flags", {busy0, done0, pass0, timeout0, fv0}, 0);
        chk("rst_err", err0, 0);
        chk("rst_vec_cov", {fev0, cov0}, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Correct sweep
        do_start();
        s = cyc;
        chk("sweep_busy", busy0, 1);
        q0.push_back(mk(1, 0, 8'd0, 0, 4'd0, 16'hFFFF, s + 31));
        sweep(-1, -1, 1'b0);
        drain("sweep");
        chk("sweep_done_level", done0, 1);
        put(4'd0, 1'b0);
        chk("done_frozen_err", err0, 0);
        chk("done_frozen_done", {done0, busy0, pass0}, 3'b101);

        // Single fault on vector 0
        do_start();
        s = cyc;
        q0.push_back(mk(0, 0, 8'd1, 1, 4'd0, 16'hFFFF, s + 31));
        sweep(-1, 0, 1'b0);
        drain("fault");

        // Missing vector 15 on the 64-cycle timeout instance
        do_start();
        s = cyc;
        q1.push_back(mk(0, 1, 8'd0, 0, 4'd0, 16'h7FFF, s + 64));
        sweep(15, -1, 1'b0);
        drain("missing");

        // Saturation: 300 faults on vector 0011, then the rest correct
        do_start();
        s = cyc;
        q0.push_back(mk(0, 0, 8'd255, 1, 4'd3, 16'hFFFF, s + 315));
        for (int i = 0; i < 300; i++) put(4'd3, 1'b1);
        chk("sat_mid_err", err0, 255);
        for (int v = 0; v < 16; v++) begin
            if (v == 3) continue;
            put(4'(v), (v == 0));
        end
        drain("sat");

        // Restart: 5 faults, then a clean run
        do_start();
        for (int i = 0; i < 5; i++) put(4'd5, 1'b1);
        chk("restart_err5", err0, 5);
        chk("restart_fev", {fv0, fev0}, 5'b10101);
        do_start();
        s = cyc;
        chk("restart_cleared", {err0, fv0, cov0}, 0);
        q0.push_back(mk(1, 0, 8'd0, 0, 4'd0, 16'hFFFF, s + 31));
        sweep(-1, -1, 1'b0);
        drain("restart");

        // start with a sample in the same cycle
        start = 1'b1;
        sample_valid = 1'b1;
        sample_abcd = 4'b0101;
        sample_e = 1'b0;
        sample_f = 1'b0;
        sample_g = 1'b1;
        tick();
        start = 1'b0;
        sample_valid = 1'b0;
        chk("start_sample_cov", cov0, 0);
        chk("start_sample_err", {err0, fv0}, 0);
        chk("start_sample_busy", busy0, 1);

        // Reset mid-CHECK
        put(4'd2, 1'b1);
        chk("pre_reset_err", err0, 1);
        resetn = 1'b0;
        #1;
        chk("midrst_flags", {busy0, done0, pass0, timeout0, fv0}, 0);
        chk("midrst_err", err0, 0);
        chk("midrst_vec_cov", {fev0, cov0}, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        chk("post_reset_idle", {busy0, done0}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nor_response_checker.md
Name: nor_response_checker

Overview:
Synthesizable self-checking receiver for the 4-input NOR datapath (inputs a,b,c,d; outputs e,f,g). It sits on the response side of the exhaustive stimulus sweep and observes each applied input vector together with the DUT outputs. For every sample it checks g against the golden value NOR(a,b,c,d). It records which of the 16 input combinations were covered, counts mismatches, captures the first failing vector, and reports pass, fail or timeout.

Parameters:
ERR_CNT_W, 8, width of the saturating mismatch counter
TIMEOUT_CYCLES, 1024, cycles allowed in CHECK before full coverage must be reached; must be >= 16

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; clears results and begins a check run
sample_valid  input  1  current cycle carries a sample to check
sample_abcd  input  4  applied vector {a,b,c,d}; a is the MSB
sample_e  input  1  DUT output e
sample_f  input  1  DUT output f
sample_g  input  1  DUT output g (4-input NOR result)
busy  output  1  high while in CHECK
done  output  1  high in DONE; held until the next start
pass  output  1  valid when done: full coverage and zero mismatches
timeout  output  1  valid when done: run ended by timeout
err_count  output  ERR_CNT_W  mismatch count, saturating at all-ones
first_err_valid  output  1  a mismatch has been captured this run
first_err_vec  output  4  sample_abcd of the first mismatch
coverage  output  16  bit i set once vector i has been sampled

Behaviour:
- Reset, asynchronous on resetn low: state=IDLE; every output is 0, including the timer.
- All outputs are registered. A sample's effect appears on the outputs the cycle after it is presented.
- FSM states: IDLE, CHECK, DONE.
- IDLE: start -> CHECK. sample_valid is ignored in IDLE.
- On start from any state, in a single cycle:
  - clear err_count, coverage, first_err_*, pass, timeout and the timer;
  - go to CHECK.
  - A sample presented in the same cycle as start is discarded.
- CHECK, when sample_valid=1:
  - exp_g = ~|sample_abcd.
  - Set coverage[sample_abcd].
  - If sample_g != exp_g: increment err_count, saturating (no wrap).
  - On the first mismatch of the run only: first_err_vec <= sample_abcd and first_err_valid <= 1. Later mismatches do not overwrite the capture.
  - Repeated vectors are checked every time; coverage is unaffected by repeats.
- CHECK timer: increments every cycle in CHECK.
- Coverage completion: when coverage including the current sample = 16'hFFFF, next state is DONE.
  - pass = 1 only if err_count was 0 and the current sample also matched.
  - timeout = 0.
- Timeout: if the timer reaches TIMEOUT_CYCLES-1 without full coverage, next state is DONE with timeout=1 and pass=0.
- If completion and timeout occur in the same cycle, completion wins.
- DONE: all results are frozen and samples are ignored. start -> CHECK (new run).
- busy = (state==CHECK); done = (state==DONE).
- resetn low mid-run: immediate return to the reset values; no partial results are retained.

Optional Feature:
Macro NOR_STAGE_CHECK_EN.
- Defined: also check the intermediate stages.
  - sample_e vs ~(a|b) and sample_f vs ~(c|d).
  - Any of the three mismatching counts as one error for that sample: one err_count increment and first-error capture.
- Undefined: sample_e and sample_f are unused and only g is checked.

Decomposition:
- Shared package nor_chk_pkg holds:
  - the state enum (IDLE/CHECK/DONE);
  - localparam NUM_VECS=16 and COV_FULL=16'hFFFF;
  - the golden function nor4_expected(vec).
- One sub-module, nor_golden_model: combinational expected e/f/g from a 4-bit vector, also reusable by the stimulus side. Counter, timer and FSM stay in the top.

Test Plan:
- Correct sweep: start, then vectors 0..15, one every 2 cycles, with g=(vec==0). Required: done=1 the cycle after vector 15, pass=1, err_count=0, coverage=FFFF, timeout=0.
- Single fault: same sweep, but vector 4'b0000 is reported with g=0. Required: err_count=1, first_err_valid=1, first_err_vec=0000, pass=0, done=1.
- Missing vector: TIMEOUT_CYCLES=64; sweep omits vector 15. Required: done at cycle 64 after start, timeout=1, pass=0, coverage=7FFF.
- Saturation: ERR_CNT_W=8; 300 faulty samples of vector 0011 with g=1, then the remaining vectors correct. Required: err_count=255 with no wrap, first_err_vec=0011.
- Restart and reset: start, then 5 faulty samples, then start again and a correct sweep. Required: err_count=0 and pass=1. Separately, drop resetn low mid-CHECK. Required: all outputs 0 immediately and state IDLE.
- start+sample same cycle: start with sample_valid=1 and a faulty vector 0101. Required: coverage=0 and err_count=0 in the next cycle.
